// File: rtl/gcd_operand_sequencer.sv
// Operand sequencer for the GCD core: loads two switch operands, pulses Start, captures the result, pulses Ack.
// Define GCD_SEQ_TIMEOUT_EN to add a RUN watchdog that parks a hung core in ERR with Err=10.
module gcd_operand_sequencer #(
  parameter  int unsigned TIMEOUT = 1000,
  parameter  int unsigned TMO_W   = 10,
  localparam int unsigned DW      = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [DW-1:0] Sw,
  input  logic          BtnLoad,
  input  logic          BtnAck,
  input  logic          CoreDone,
  input  logic [DW-1:0] CoreGcd,
  output logic [DW-1:0] Ain,
  output logic [DW-1:0] Bin,
  output logic          Start,
  output logic          Ack,
  output logic [DW-1:0] Result,
  output logic          ResultValid,
  output logic [1:0]    Err,
  output logic          q_LoadA,
  output logic          q_LoadB,
  output logic          q_Run,
  output logic          q_Show,
  output logic          q_Err
);

  typedef enum logic [4:0] {
    LOADA = 5'b00001,
    LOADB = 5'b00010,
    RUN   = 5'b00100,
    SHOW  = 5'b01000,
    ERR   = 5'b10000
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ZERO = 2'b01;

  state_t state;
  logic   sw_zero_c;

  assign sw_zero_c = (Sw == '0);
  assign {q_Err, q_Show, q_Run, q_LoadB, q_LoadA} = state;

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam logic [1:0] ERR_TMO = 2'b10;
  logic [TMO_W-1:0] tmo_cnt;
`else
  logic unused_cfg_c;
  assign unused_cfg_c = ^{TIMEOUT, TMO_W};
`endif

  // Single-process FSM; Start/Ack default low so each is a one-cycle pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= LOADA;
      Ain         <= '0;
      Bin         <= '0;
      Result      <= '0;
      Start       <= 1'b0;
      Ack         <= 1'b0;
      ResultValid <= 1'b0;
      Err         <= ERR_NONE;
`ifdef GCD_SEQ_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      Start <= 1'b0;
      Ack   <= 1'b0;
      case (state)
        LOADA: begin
          if (BtnLoad) begin
            if (sw_zero_c) begin
              Err   <= ERR_ZERO;
              state <= ERR;
            end else begin
              Ain   <= Sw;
              state <= LOADB;
            end
          end
        end
        LOADB: begin
          if (BtnAck) begin
            state <= LOADA;
          end else if (BtnLoad) begin
            if (sw_zero_c) begin
              Err   <= ERR_ZERO;
              state <= ERR;
            end else begin
              Bin   <= Sw;
              Start <= 1'b1;
              state <= RUN;
`ifdef GCD_SEQ_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
        end
        RUN: begin
`ifdef GCD_SEQ_TIMEOUT_EN
          tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          // A done arriving on the expiry cycle still wins over the timeout
          if (CoreDone) begin
            Result      <= CoreGcd;
            ResultValid <= 1'b1;
            state       <= SHOW;
          end
`ifdef GCD_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            Err   <= ERR_TMO;
            state <= ERR;
          end
`endif
        end
        SHOW: begin
          if (BtnAck) begin
            Ack         <= 1'b1;
            ResultValid <= 1'b0;
            state       <= LOADA;
          end
        end
        ERR: begin
          // Zero-operand errors clear on Ack without pulsing the core; timeouts stay until Reset
          if (BtnAck && (Err == ERR_ZERO)) begin
            Err   <= ERR_NONE;
            state <= LOADA;
          end
        end
        default: state <= LOADA;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Self-checking bench for gcd_operand_sequencer: vector table of full runs plus hand-written corner sequences.
module tb_gcd_operand_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] Sw;
  logic       BtnLoad, BtnAck, CoreDone;
  logic [7:0] CoreGcd;
  logic [7:0] Ain, Bin, Result;
  logic       Start, Ack, ResultValid;
  logic [1:0] Err;
  logic       q_LoadA, q_LoadB, q_Run, q_Show, q_Err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         delay;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] sb_q[$];
  logic [7:0] exp_res;
  logic [7:0] last_bin;

  gcd_operand_sequencer #(.TIMEOUT(1000), .TMO_W(10)) dut (
    .Clk(Clk), .Reset(Reset), .Sw(Sw), .BtnLoad(BtnLoad), .BtnAck(BtnAck),
    .CoreDone(CoreDone), .CoreGcd(CoreGcd), .Ain(Ain), .Bin(Bin), .Start(Start),
    .Ack(Ack), .Result(Result), .ResultValid(ResultValid), .Err(Err),
    .q_LoadA(q_LoadA), .q_LoadB(q_LoadB), .q_Run(q_Run), .q_Show(q_Show), .q_Err(q_Err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    int x = a;
    int y = b;
    while (y != 0) begin
      int t = x % y;
      x = y;
      y = t;
    end
    return 8'(x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] v);
    Sw = v;
    BtnLoad = 1'b1;
    tick();
    BtnLoad = 1'b0;
  endtask

  task automatic pulse_ack();
    BtnAck = 1'b1;
    tick();
    BtnAck = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #3;
    Reset = 1'b0;
    tick();
  endtask

  // Full run: two loads, core done after 'delay' RUN cycles, then acknowledge
  task automatic run_vec(input vec_t v);
    int n;
    pulse_load(v.a);
    check("loadA_state", q_LoadB, 1);
    check("Ain", Ain, v.a);
    pulse_load(v.b);
    check("start_pulse", Start, 1);
    check("run_state", q_Run, 1);
    check("Bin", Bin, v.b);
    sb_q.push_back(gcd_ref(v.a, v.b));
    last_bin = v.b;
    if (v.delay > 0) begin
      tick();
      check("start_single", Start, 0);
      repeat (v.delay - 1) tick();
    end
    CoreDone = 1'b1;
    CoreGcd  = gcd_ref(v.a, v.b);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ResultValid && n < 10);
    CoreDone = 1'b0;
    check("done_latency", n, 1);
    check("show_state", q_Show, 1);
    exp_res = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    check("Result", Result, exp_res);
    pulse_load(8'd99);
    check("show_ignores_load", q_Show, 1);
    pulse_ack();
    check("ack_pulse", Ack, 1);
    check("ack_to_loada", q_LoadA, 1);
    check("rv_cleared", ResultValid, 0);
    tick();
    check("ack_single", Ack, 0);
    check("result_held", Result, exp_res);
  endtask

  initial begin
    vecs[0] = '{a: 8'd36,  b: 8'd24,  delay: 5};
    vecs[1] = '{a: 8'd255, b: 8'd17,  delay: 1};
    vecs[2] = '{a: 8'd1,   b: 8'd1,   delay: 0};
    vecs[3] = '{a: 8'd128, b: 8'd96,  delay: 3};
    vecs[4] = '{a: 8'd200, b: 8'd255, delay: 7};

    Reset = 1'b1; Sw = '0; BtnLoad = 1'b0; BtnAck = 1'b0; CoreDone = 1'b0; CoreGcd = '0;
    #12;
    check("rst_state", {q_Err, q_Show, q_Run, q_LoadB, q_LoadA}, 5'b00001);
    check("rst_regs", {Ain, Bin, Result}, 24'h0);
    check("rst_flags", {Start, Ack, ResultValid, Err}, 5'b0);
    Reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // BtnAck in LOADA is ignored
    pulse_ack();
    check("loada_ignores_ack", q_LoadA, 1);

    // Zero operand A, then zero operand B
    pulse_load(8'd0);
    check("zeroA_state", q_Err, 1);
    check("zeroA_err", Err, 1);
    pulse_ack();
    check("zeroA_clear", {q_LoadA, Err, Ack}, {1'b1, 2'b00, 1'b0});
    pulse_load(8'd5);
    pulse_load(8'd0);
    check("zeroB_state", q_Err, 1);
    check("zeroB_err", Err, 1);
    check("zeroB_nostart", Start, 0);
    pulse_ack();
    check("zeroB_clear", {q_LoadA, Err, Ack}, {1'b1, 2'b00, 1'b0});
    tick();
    check("zeroB_noack", Ack, 0);

    // Abort: Load and Ack together in LOADB
    pulse_load(8'd7);
    Sw = 8'd9; BtnLoad = 1'b1; BtnAck = 1'b1;
    tick();
    BtnLoad = 1'b0; BtnAck = 1'b0;
    check("abort_state", q_LoadA, 1);
    check("abort_bin", Bin, last_bin);
    check("abort_ain", Ain, 8'd7);
    check("abort_nostart", Start, 0);

    // RUN ignores buttons; reset mid-RUN clears everything asynchronously
    pulse_load(8'd12);
    pulse_load(8'd8);
    check("mid_start", Start, 1);
    BtnAck = 1'b1; BtnLoad = 1'b1;
    tick();
    BtnAck = 1'b0; BtnLoad = 1'b0;
    check("run_ignores_btn", q_Run, 1);
    #2 Reset = 1'b1;
    #1;
    check("async_state", {q_Err, q_Show, q_Run, q_LoadB, q_LoadA}, 5'b00001);
    check("async_regs", {Ain, Bin, Result, Start, Ack, ResultValid, Err}, 29'h0);
    Reset = 1'b0;
    tick();
    last_bin = 8'd0;

`ifdef GCD_SEQ_TIMEOUT_EN
    // Done/timeout race: done on the cycle the counter reads 999
    pulse_load(8'd45);
    pulse_load(8'd30);
    repeat (999) tick();
    check("race_still_run", q_Run, 1);
    CoreDone = 1'b1; CoreGcd = gcd_ref(8'd45, 8'd30);
    tick();
    CoreDone = 1'b0;
    check("race_show", q_Show, 1);
    check("race_err", Err, 0);
    check("race_result", Result, 8'd15);
    pulse_ack();

    // Timeout: Err=10 exactly 1000 cycles after entering RUN, sticky until Reset
    pulse_load(8'd3);
    pulse_load(8'd4);
    repeat (999) tick();
    check("tmo_before", {q_Run, Err}, {1'b1, 2'b00});
    tick();
    check("tmo_state", q_Err, 1);
    check("tmo_err", Err, 2);
    pulse_ack();
    check("tmo_sticky", {q_Err, Err, Ack}, {1'b1, 2'b10, 1'b0});
    do_reset();
    check("tmo_reset", {q_LoadA, Err}, {1'b1, 2'b00});
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
